// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for a 5-stage (F/D/X/M/W) RISC-V core.
//
// Keeps a shadow pipeline of register tags and control bits (X, M, W) and
// derives, combinationally from that state and the D-stage decode inputs:
//   - load-use and branch-compare stalls (stall_f, stall_d, flush_x)
//   - taken-branch/jump flush of the F/D register (flush_d)
//   - X-stage operand forwarding selects (fwd_a_x, fwd_b_x)
//   - D-stage branch-compare forwarding selects (fwd_a_d, fwd_b_d)
// Two saturating performance counters count stalled and flushed cycles.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   rs1_d, rs2_d, uses_rs*_d   source registers of the D instruction and their use flags
//   rd_d, reg_write_d          destination register of the D instruction and its write enable
//   result_src_d               D result source; SRC_LOAD marks a load
//   branch_d, pc_src_d         D is a conditional branch / D redirects the PC
//   clr_cnt                    synchronous clear of both counters
//   stall_f, stall_d           hold PC / hold F/D register
//   flush_d, flush_x           clear F/D to a NOP / clear D/X to a bubble
//   fwd_a_x, fwd_b_x           X operand select: 00 regfile, 01 W result, 10 M alu result
//   fwd_a_d, fwd_b_d           D compare operand takes M alu result
//   stall_cnt, flush_cnt       cycles with stall_d=1 / flush_d=1 (saturating)
module hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32,
    parameter logic [1:0]  SRC_LOAD = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              uses_rs1_d,
    input  logic              uses_rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic [1:0]        result_src_d,
    input  logic              branch_d,
    input  logic              pc_src_d,
    input  logic              clr_cnt,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_x,
    output logic [1:0]        fwd_a_x,
    output logic [1:0]        fwd_b_x,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    // Shadow pipeline state
    logic [REG_AW-1:0] rs1_x_q, rs1_x_d;
    logic [REG_AW-1:0] rs2_x_q, rs2_x_d;
    logic [REG_AW-1:0] rd_x_q, rd_x_d;
    logic              rw_x_q, rw_x_d;
    logic              ld_x_q, ld_x_d;
    logic [REG_AW-1:0] rd_m_q, rd_m_d;
    logic              rw_m_q, rw_m_d;
    logic              ld_m_q, ld_m_d;
    logic [REG_AW-1:0] rd_w_q, rd_w_d;
    logic              rw_w_q, rw_w_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // x0 is hardwired, so a write to it is never a dependency.
    function automatic logic tag_match(input logic              rw,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
        return rw && (rd != '0) && (rd == rs);
    endfunction

    // M has priority over W: it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit) begin
            return 2'b10;
        end else if (w_hit) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    logic hit_x_d;
    logic hit_m_d;
    logic lu_stall;
    logic br_stall;
    logic stall;

    always_comb begin
        hit_x_d = (uses_rs1_d && tag_match(rw_x_q, rd_x_q, rs1_d)) ||
                  (uses_rs2_d && tag_match(rw_x_q, rd_x_q, rs2_d));
        hit_m_d = (uses_rs1_d && tag_match(rw_m_q, rd_m_q, rs1_d)) ||
                  (uses_rs2_d && tag_match(rw_m_q, rd_m_q, rs2_d));

        lu_stall = ld_x_q && hit_x_d;
        // The branch compares in D, so any X producer is too late, and a load
        // in M has no data until W.
        br_stall = branch_d && (hit_x_d || (ld_m_q && hit_m_d));
        stall    = lu_stall || br_stall;

        stall_f = stall;
        stall_d = stall;
        flush_x = stall;
        // A stalled branch is re-evaluated next cycle, so it must not flush yet.
        flush_d = pc_src_d && !stall && !reset;

        fwd_a_x = fwd_sel(tag_match(rw_m_q, rd_m_q, rs1_x_q), tag_match(rw_w_q, rd_w_q, rs1_x_q));
        fwd_b_x = fwd_sel(tag_match(rw_m_q, rd_m_q, rs2_x_q), tag_match(rw_w_q, rd_w_q, rs2_x_q));

        // W results reach D through the regfile (written on the negedge).
        fwd_a_d = tag_match(rw_m_q, rd_m_q, rs1_d) && !ld_m_q;
        fwd_b_d = tag_match(rw_m_q, rd_m_q, rs2_d) && !ld_m_q;
    end

    // Next-state of the shadow pipeline
    always_comb begin
        rs1_x_d = rs1_d;
        rs2_x_d = rs2_d;
        rd_x_d  = rd_d;
        rw_x_d  = reg_write_d;
        ld_x_d  = (result_src_d == SRC_LOAD);
        if (flush_x) begin
            rs1_x_d = '0;
            rs2_x_d = '0;
            rd_x_d  = '0;
            rw_x_d  = 1'b0;
            ld_x_d  = 1'b0;
        end
        rd_m_d = rd_x_q;
        rw_m_d = rw_x_q;
        ld_m_d = ld_x_q;
        rd_w_d = rd_m_q;
        rw_w_d = rw_m_q;
    end

    // Counters: clear wins over increment; saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_d && (stall_cnt_q != CntMax)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_d && (flush_cnt_q != CntMax)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_x_q     <= '0;
            rs2_x_q     <= '0;
            rd_x_q      <= '0;
            rw_x_q      <= 1'b0;
            ld_x_q      <= 1'b0;
            rd_m_q      <= '0;
            rw_m_q      <= 1'b0;
            ld_m_q      <= 1'b0;
            rd_w_q      <= '0;
            rw_w_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            rs1_x_q     <= rs1_x_d;
            rs2_x_q     <= rs2_x_d;
            rd_x_q      <= rd_x_d;
            rw_x_q      <= rw_x_d;
            ld_x_q      <= ld_x_d;
            rd_m_q      <= rd_m_d;
            rw_m_q      <= rw_m_d;
            ld_m_q      <= ld_m_d;
            rd_w_q      <= rd_w_d;
            rw_w_q      <= rw_w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
